// File: rtl/i2c_wbs_arbiter_if.sv
// Wishbone register-port link between a host and the shared I2C master.
// One instance per link; the requester side uses 'master', the responder side uses 'slave'.
// err only travels back toward a requester; the shared slave port never raises it.
interface i2c_wbs_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int SEL_W  = 2
);
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] wdat;
  logic [DATA_W-1:0] rdat;
  logic [SEL_W-1:0]  sel;
  logic              we;
  logic              stb;
  logic              cyc;
  logic              ack;
  logic              err;

  modport master (output adr, wdat, sel, we, stb, cyc, input rdat, ack);
  modport slave  (input adr, wdat, sel, we, stb, cyc, output rdat, ack, err);
endinterface

// File: rtl/i2c_wbs_arbiter.sv
// Two-host round-robin arbiter in front of the I2C master's Wishbone register port.
// Grant takes one IDLE cycle; while granted, the bus is a zero-latency combinational pass-through.
// The holder keeps the slave for its whole CYC; the loser sees ack=0; a stalled STB is aborted by the watchdog.
module i2c_wbs_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int SEL_W   = 2,   // tie the select inputs off when DATA_W=8
  parameter int TIMEOUT = 255  // stalled STB cycles before abort; 0 disables the watchdog
) (
  input  logic                clk,
  input  logic                rst,
  i2c_wbs_arbiter_if.slave    m0,
  i2c_wbs_arbiter_if.slave    m1,
  i2c_wbs_arbiter_if.master   s,
  output logic [1:0]          gnt_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, ERR} state_t;

  state_t           state;
  logic             last_gnt;  // master served most recently; the other one wins a tie
  logic             own;       // master that holds (or held, in ERR) the slave
  logic [CNT_W-1:0] wd_cnt;
  logic             err0_q;
  logic             err1_q;

  logic g_cyc;
  logic g_stb;
  logic stall;
  logic expire;

  // Request lines of whichever master currently holds the grant.
  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    case (state)
      GNT0: begin
        g_cyc = m0.cyc;
        g_stb = m0.stb;
      end
      GNT1: begin
        g_cyc = m1.cyc;
        g_stb = m1.stb;
      end
      default: ;
    endcase
    stall  = g_cyc & g_stb & ~s.ack;
    // An ack in the last allowed stall cycle still completes, because stall already excludes it.
    expire = (TIMEOUT != 0) && stall && (wd_cnt == CNT_LAST);
  end

  // Arbitration FSM, watchdog counter and the one-cycle abort pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      own      <= 1'b0;
      wd_cnt   <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (m0.cyc && (!m1.cyc || last_gnt)) begin
            state <= GNT0;
            own   <= 1'b0;
          end else if (m1.cyc) begin
            state <= GNT1;
            own   <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          if (!g_cyc) begin
            state    <= IDLE;
            last_gnt <= own;
            wd_cnt   <= '0;
          end else if (expire) begin
            state  <= ERR;
            wd_cnt <= '0;
            err0_q <= ~own;
            err1_q <= own;
          end else if (stall && (TIMEOUT != 0)) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end else begin
            wd_cnt <= '0;
          end
        end
        ERR: begin
          wd_cnt <= '0;
          if (!(own ? m1.cyc : m0.cyc)) begin
            state    <= IDLE;
            last_gnt <= own;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Slave-side mux and ack routing; everything is quiet outside GNT0/GNT1.
  always_comb begin
    s.adr  = '0;
    s.wdat = '0;
    s.sel  = '0;
    s.we   = 1'b0;
    s.stb  = 1'b0;
    s.cyc  = 1'b0;
    m0.ack = 1'b0;
    m1.ack = 1'b0;
    gnt_o  = 2'b00;
    case (state)
      GNT0: begin
        s.adr  = m0.adr;
        s.wdat = m0.wdat;
        s.sel  = m0.sel;
        s.we   = m0.we;
        s.stb  = m0.stb;
        s.cyc  = m0.cyc;
        m0.ack = s.ack;
        gnt_o  = 2'b01;
      end
      GNT1: begin
        s.adr  = m1.adr;
        s.wdat = m1.wdat;
        s.sel  = m1.sel;
        s.we   = m1.we;
        s.stb  = m1.stb;
        s.cyc  = m1.cyc;
        m1.ack = s.ack;
        gnt_o  = 2'b10;
      end
      default: ;
    endcase
  end

  assign m0.rdat = s.rdat;
  assign m1.rdat = s.rdat;
  assign m0.err  = err0_q;
  assign m1.err  = err1_q;

endmodule

// File: tb/tb_i2c_wbs_arbiter.sv
// Bench for i2c_wbs_arbiter: vector table, grant/read-data scoreboards, watchdog and reset sequences.
module tb_i2c_wbs_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] gnt;
  logic [1:0] z_gnt;

  initial forever #5 clk = ~clk;

  i2c_wbs_arbiter_if #(.DATA_W(16), .ADDR_W(3), .SEL_W(2)) m0_bus ();
  i2c_wbs_arbiter_if #(.DATA_W(16), .ADDR_W(3), .SEL_W(2)) m1_bus ();
  i2c_wbs_arbiter_if #(.DATA_W(16), .ADDR_W(3), .SEL_W(2)) s_bus ();
  i2c_wbs_arbiter_if #(.DATA_W(16), .ADDR_W(3), .SEL_W(2)) z_m0_bus ();
  i2c_wbs_arbiter_if #(.DATA_W(16), .ADDR_W(3), .SEL_W(2)) z_m1_bus ();
  i2c_wbs_arbiter_if #(.DATA_W(16), .ADDR_W(3), .SEL_W(2)) z_s_bus ();

  i2c_wbs_arbiter #(.DATA_W(16), .ADDR_W(3), .SEL_W(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .m0(m0_bus), .m1(m1_bus), .s(s_bus), .gnt_o(gnt));

  i2c_wbs_arbiter #(.DATA_W(16), .ADDR_W(3), .SEL_W(2), .TIMEOUT(0)) dut0 (
    .clk(clk), .rst(rst), .m0(z_m0_bus), .m1(z_m1_bus), .s(z_s_bus), .gnt_o(z_gnt));

  int          total = 0;
  int          bad = 0;
  int          exp_gnt_q[$];
  logic [15:0] exp_rd_q[$];
  bit          mon_en = 1'b0;
  bit          slv_en = 1'b0;
  logic [1:0]  prev_gnt = 2'b00;

  typedef struct {
    logic m0c, m0s, m1c, m1s, ack;
    logic [1:0] gnt;
    logic scyc, sstb;
    logic [2:0] sadr;
    logic [15:0] sdat;
    logic a0, a1;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] rd_val(input logic [2:0] a);
    return 16'hD00D ^ {a, 5'd0, a, 5'd0};
  endfunction

  task automatic drv(input int m, input logic cyc, input logic stb, input logic we,
                     input logic [2:0] adr, input logic [15:0] dat);
    if (m == 0) begin
      m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we;
      m0_bus.adr = adr; m0_bus.wdat = dat; m0_bus.sel = 2'b11;
    end else begin
      m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we;
      m1_bus.adr = adr; m1_bus.wdat = dat; m1_bus.sel = 2'b01;
    end
  endtask

  // Responder: acks the first cycle it sees a strobe, then drops for one cycle.
  task automatic slave_loop();
    forever begin
      @(posedge clk);
      #2;
      if (slv_en) begin
        s_bus.ack  = s_bus.cyc && s_bus.stb && !s_bus.ack;
        s_bus.rdat = rd_val(s_bus.adr);
      end
    end
  endtask

  // Grant legality, loser-ack and IDLE-gap checks; grant order popped from the scoreboard.
  task automatic monitor_loop();
    bit ok;
    int e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        ok = (gnt != 2'b11) && !(gnt == 2'b01 && m1_bus.ack) && !(gnt == 2'b10 && m0_bus.ack)
             && !(gnt == 2'b00 && (m0_bus.ack || m1_bus.ack))
             && !(prev_gnt != 2'b00 && gnt != 2'b00 && gnt != prev_gnt);
        check(ok, "grant_excl", {prev_gnt, gnt, m0_bus.ack, m1_bus.ack}, {prev_gnt, gnt, 2'b00});
        if (prev_gnt == 2'b00 && gnt != 2'b00) begin
          check(exp_gnt_q.size() != 0, "gnt_unexpected", gnt, 0);
          if (exp_gnt_q.size() != 0) begin
            e = exp_gnt_q.pop_front();
            check(gnt == 2'(e), "gnt_order", gnt, e);
          end
        end
        prev_gnt = gnt;
      end
    end
  endtask

  task automatic bus_xfer(input int m, input logic we, input logic [2:0] adr, input logic [15:0] dat);
    bit got = 1'b0;
    logic [15:0] e;
    if (!we) exp_rd_q.push_back(rd_val(adr));
    drv(m, 1'b1, 1'b1, we, adr, dat);
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if ((m == 0) ? m0_bus.ack : m1_bus.ack) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check(got, "xfer_ack", got, 1);
    if (got) begin
      check(gnt == ((m == 0) ? 2'b01 : 2'b10), "ack_gnt", gnt, (m == 0) ? 1 : 2);
      check(s_bus.adr == adr && s_bus.we == we && (!we || s_bus.wdat == dat), "xfer_bus",
            {s_bus.adr, s_bus.we, s_bus.wdat}, {adr, we, dat});
    end
    if (!we && exp_rd_q.size() != 0) begin
      e = exp_rd_q.pop_front();
      if (got) check(((m == 0) ? m0_bus.rdat : m1_bus.rdat) == e, "rd_data",
                     (m == 0) ? m0_bus.rdat : m1_bus.rdat, e);
    end
    @(posedge clk);
    #1;
    drv(m, 1'b1, 1'b0, we, adr, dat);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n, errs, err_at;
    bit hit;
    drv(0, 0, 0, 0, 3'd0, 16'h0);
    drv(1, 0, 0, 0, 3'd0, 16'h0);
    s_bus.ack = 1'b1; s_bus.rdat = 16'h0;
    z_m0_bus.cyc = 0; z_m0_bus.stb = 0; z_m0_bus.we = 0; z_m0_bus.adr = 0; z_m0_bus.wdat = 0; z_m0_bus.sel = 0;
    z_m1_bus.cyc = 0; z_m1_bus.stb = 0; z_m1_bus.we = 0; z_m1_bus.adr = 0; z_m1_bus.wdat = 0; z_m1_bus.sel = 0;
    z_s_bus.ack = 0; z_s_bus.rdat = 16'h0;
    fork
      slave_loop();
      monitor_loop();
    join_none

    // Reset state, with a slave ack present that must not leak through.
    repeat (2) @(posedge clk);
    #1;
    check({gnt, s_bus.cyc, s_bus.stb, s_bus.we, s_bus.adr, s_bus.wdat, s_bus.sel,
           m0_bus.ack, m1_bus.ack, m0_bus.err, m1_bus.err} == '0, "reset_outputs",
          {gnt, s_bus.cyc, s_bus.stb, s_bus.we, s_bus.adr, s_bus.wdat, s_bus.sel,
           m0_bus.ack, m1_bus.ack, m0_bus.err, m1_bus.err}, 0);
    s_bus.ack = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    tbl[0]  = '{1,1,0,0,0, 2'b00,0,0,3'd0,16'h0000,0,0};
    tbl[1]  = '{1,1,0,0,0, 2'b01,1,1,3'd2,16'hA55A,0,0};
    tbl[2]  = '{1,1,0,0,1, 2'b01,1,1,3'd2,16'hA55A,1,0};
    tbl[3]  = '{0,0,0,0,0, 2'b01,0,0,3'd2,16'hA55A,0,0};
    tbl[4]  = '{1,1,1,1,0, 2'b00,0,0,3'd0,16'h0000,0,0};
    tbl[5]  = '{1,1,1,1,1, 2'b10,1,1,3'd5,16'h1234,0,1};
    tbl[6]  = '{1,1,0,0,1, 2'b10,0,0,3'd5,16'h1234,0,1};
    tbl[7]  = '{1,1,0,0,0, 2'b00,0,0,3'd0,16'h0000,0,0};
    tbl[8]  = '{1,1,0,0,0, 2'b01,1,1,3'd2,16'hA55A,0,0};
    tbl[9]  = '{0,0,0,0,0, 2'b01,0,0,3'd2,16'hA55A,0,0};
    tbl[10] = '{0,0,0,0,0, 2'b00,0,0,3'd0,16'h0000,0,0};
    for (int i = 0; i < 11; i++) begin
      drv(0, tbl[i].m0c, tbl[i].m0s, 1'b1, 3'd2, 16'hA55A);
      drv(1, tbl[i].m1c, tbl[i].m1s, 1'b0, 3'd5, 16'h1234);
      s_bus.ack = tbl[i].ack;
      @(negedge clk);
      check({gnt, s_bus.cyc, s_bus.stb, s_bus.adr, s_bus.wdat, m0_bus.ack, m1_bus.ack} ==
            {tbl[i].gnt, tbl[i].scyc, tbl[i].sstb, tbl[i].sadr, tbl[i].sdat, tbl[i].a0, tbl[i].a1},
            $sformatf("vec%0d", i),
            {gnt, s_bus.cyc, s_bus.stb, s_bus.adr, s_bus.wdat, m0_bus.ack, m1_bus.ack},
            {tbl[i].gnt, tbl[i].scyc, tbl[i].sstb, tbl[i].sadr, tbl[i].sdat, tbl[i].a0, tbl[i].a1});
      @(posedge clk);
      #1;
    end
    s_bus.ack = 1'b0;

    // Fresh reset so m0 wins the first tie again.
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    prev_gnt = 2'b00;
    mon_en = 1'b1;
    slv_en = 1'b1;

    // Simultaneous requests: grants must alternate m0, m1, m0, ...
    for (int r = 0; r < 3; r++) begin
      exp_gnt_q.push_back(1);
      exp_gnt_q.push_back(2);
      drv(0, 1, 0, 1, 3'd2, 16'hA55A);
      drv(1, 1, 0, 0, 3'(r + 4), 16'h0);
      fork
        begin
          bus_xfer(0, 1'b1, 3'd2, 16'hA55A);
          drv(0, 0, 0, 1, 3'd2, 16'hA55A);
        end
        begin
          bus_xfer(1, 1'b0, 3'(r + 4), 16'h0);
          drv(1, 0, 0, 0, 3'(r + 4), 16'h0);
        end
      join
      @(posedge clk);
      #1;
    end

    // m1 holds the bus for four reads while m0 waits.
    exp_gnt_q.push_back(2);
    exp_gnt_q.push_back(1);
    drv(1, 1, 0, 0, 3'd0, 16'h0);
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          bus_xfer(1, 1'b0, 3'(i), 16'h0);
          @(posedge clk);
          #1;
        end
        drv(1, 0, 0, 0, 3'd0, 16'h0);
      end
      begin
        @(posedge clk);
        #1;
        drv(0, 1, 0, 1, 3'd7, 16'h0F0F);
        bus_xfer(0, 1'b1, 3'd7, 16'h0F0F);
        drv(0, 0, 0, 1, 3'd7, 16'h0F0F);
      end
    join
    @(posedge clk);
    #1;

    // Watchdog abort: 8 stalled cycles, then a pending m1 gets the bus.
    slv_en = 1'b0;
    s_bus.ack = 1'b0;
    exp_gnt_q.push_back(1);
    exp_gnt_q.push_back(2);
    drv(0, 1, 1, 0, 3'd1, 16'h0);
    n = 0; errs = 0; err_at = -1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (m0_bus.err) begin
        errs++;
        if (err_at < 0) begin
          err_at = n;
          check(!s_bus.cyc && !s_bus.stb && gnt == 2'b00 && !m0_bus.ack, "err_bus_idle",
                {s_bus.cyc, s_bus.stb, gnt, m0_bus.ack}, 0);
        end
      end
      if (m1_bus.err) errs = errs + 100;
      if (gnt == 2'b01) n++;
      @(posedge clk);
      #1;
      if (i == 1) drv(1, 1, 1, 0, 3'd3, 16'h0);
    end
    check(err_at == 8, "err_after_stalls", err_at, 8);
    check(errs == 1, "err_pulse_width", errs, 1);
    drv(0, 0, 0, 0, 3'd1, 16'h0);
    slv_en = 1'b1;
    bus_xfer(1, 1'b0, 3'd3, 16'h0);
    drv(1, 0, 0, 0, 3'd3, 16'h0);
    @(posedge clk);
    #1;

    // Ack in the eighth stalled cycle completes normally.
    slv_en = 1'b0;
    s_bus.ack = 1'b0;
    exp_gnt_q.push_back(1);
    drv(0, 1, 1, 1, 3'd4, 16'hBEEF);
    n = 0; errs = 0; hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m0_bus.err) errs++;
      if (s_bus.ack) begin
        check(m0_bus.ack == 1'b1 && gnt == 2'b01, "ack_last_stall", {gnt, m0_bus.ack}, 3'b011);
        hit = 1'b1;
      end
      if (gnt == 2'b01) n++;
      @(posedge clk);
      #1;
      if (s_bus.ack) begin
        s_bus.ack = 1'b0;
        drv(0, 0, 0, 1, 3'd4, 16'hBEEF);
      end else if (n == 7 && !hit) begin
        s_bus.ack = 1'b1;
      end
    end
    check(hit, "ack_last_stall_seen", hit, 1);
    check(errs == 0, "no_err_on_late_ack", errs, 0);

    // Watchdog disabled: a 1000-cycle stall never aborts.
    z_m0_bus.cyc = 1'b1; z_m0_bus.stb = 1'b1; z_m0_bus.adr = 3'd2;
    n = 0; errs = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (z_m0_bus.err) errs++;
      if (z_gnt == 2'b01) n++;
    end
    check(errs == 0, "t0_no_err", errs, 0);
    check(n == 999, "t0_gnt_held", n, 999);
    @(posedge clk);
    #1;
    z_s_bus.ack = 1'b1;
    @(negedge clk);
    check(z_m0_bus.ack && z_gnt == 2'b01, "t0_ack", {z_gnt, z_m0_bus.ack}, 3'b011);
    @(posedge clk);
    #1;
    z_s_bus.ack = 1'b0; z_m0_bus.cyc = 1'b0; z_m0_bus.stb = 1'b0;

    // Asynchronous reset in the middle of an m1 access.
    exp_gnt_q.push_back(2);
    drv(1, 1, 1, 1, 3'd6, 16'h5A5A);
    for (int i = 0; i < 10 && gnt != 2'b10; i++) @(negedge clk);
    check(gnt == 2'b10, "pre_rst_gnt1", gnt, 2);
    #2;
    rst = 1'b0;
    s_bus.ack = 1'b1;
    drv(0, 1, 1, 0, 3'd1, 16'h0);
    #1;
    check({gnt, s_bus.cyc, s_bus.stb, s_bus.we, s_bus.adr, s_bus.wdat, s_bus.sel,
           m0_bus.ack, m1_bus.ack, m0_bus.err, m1_bus.err} == '0, "async_rst_outputs",
          {gnt, s_bus.cyc, s_bus.stb, s_bus.we, s_bus.adr, s_bus.wdat, s_bus.sel,
           m0_bus.ack, m1_bus.ack, m0_bus.err, m1_bus.err}, 0);
    repeat (2) @(posedge clk);
    s_bus.ack = 1'b0;
    exp_gnt_q.push_back(1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check(gnt == 2'b01, "post_rst_m0_wins", gnt, 1);
    @(posedge clk);
    #1;
    drv(0, 0, 0, 0, 3'd0, 16'h0);
    drv(1, 0, 0, 0, 3'd0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    check(exp_gnt_q.size() == 0, "gnt_queue_drained", exp_gnt_q.size(), 0);
    check(exp_rd_q.size() == 0, "rd_queue_drained", exp_rd_q.size(), 0);
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_wbs_arbiter.md
Name: i2c_wbs_arbiter

Overview:
- Two-master to one-slave Wishbone arbiter that shares a single i2c_master_wbs_16 (or _8) register interface between two hosts, for example a CPU bus and an autonomous sensor-poll sequencer.
- Arbitration is round-robin and cycle-locked: a master keeps the slave for the whole time its CYC is asserted.
- A watchdog aborts a stalled access with an error strobe, so a hung slave cannot lock out the other master.
- Sits directly in front of the I2C master's wbs_* port.

Parameters:
- DATA_W, 16, Wishbone data width (16 or 8).
- ADDR_W, 3, Wishbone address width.
- SEL_W, 2, byte-select width. Tie off when DATA_W=8.
- TIMEOUT, 255, number of stalled STB cycles before abort. 0 disables the watchdog. Range 0..65535.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- m0_adr_i, m1_adr_i  in  ADDR_W  master address.
- m0_dat_i, m1_dat_i  in  DATA_W  master write data.
- m0_sel_i, m1_sel_i  in  SEL_W  master byte selects.
- m0_we_i, m1_we_i  in  1  master write enable.
- m0_stb_i, m1_stb_i  in  1  master strobe.
- m0_cyc_i, m1_cyc_i  in  1  master cycle.
- m0_dat_o, m1_dat_o  out  DATA_W  read data; both driven from s_dat_i.
- m0_ack_o, m1_ack_o  out  1  acknowledge to the granted master only.
- m0_err_o, m1_err_o  out  1  one-cycle timeout-abort pulse.
- s_adr_o  out  ADDR_W  slave address.
- s_dat_o  out  DATA_W  slave write data.
- s_sel_o  out  SEL_W  slave byte selects.
- s_we_o  out  1  slave write enable.
- s_stb_o  out  1  slave strobe.
- s_cyc_o  out  1  slave cycle.
- s_dat_i  in  DATA_W  slave read data.
- s_ack_i  in  1  slave acknowledge.
- gnt_o  out  2  one-hot current grant; 00 when IDLE or ERR.

Behaviour:
- State machine states: IDLE, GNT0, GNT1, ERR. State register and last_gnt register (1 bit) are both asynchronously reset.
- Reset (rst low, any time, including mid-transfer):
  - state = IDLE, last_gnt = 1, so m0 wins the first contention.
  - Watchdog counter = 0.
  - All s_* outputs = 0, all m*_ack_o and m*_err_o = 0, gnt_o = 00.
- IDLE:
  - s_cyc_o, s_stb_o, s_we_o = 0; s_adr_o, s_dat_o, s_sel_o = 0.
  - Transitions evaluated on each clk edge:
    - only m0_cyc_i -> GNT0; only m1_cyc_i -> GNT1.
    - both asserted -> grant the master not equal to last_gnt.
    - neither -> stay in IDLE.
  - Grant latency: a request sampled at edge N appears on s_* in the cycle after edge N. A minimum of 1 cycle in IDLE always precedes a grant.
- GNTx:
  - s_adr/dat/sel/we/stb/cyc_o are a combinational pass-through of master x.
  - mx_ack_o = s_ack_i. The other master's ack and err = 0.
  - gnt_o bit x = 1.
  - Master x deasserts cyc -> IDLE, last_gnt = x. s_cyc_o falls in the same cycle, since it is combinational.
  - Multiple STB transfers within one CYC stay granted (bus lock). The other master waits, with ack 0.
- Watchdog (TIMEOUT > 0):
  - Counter increments each GNTx cycle with stb & cyc & !s_ack_i.
  - Clears on s_ack_i, on stb low, or on any state change.
  - Counter == TIMEOUT-1 with no ack -> ERR on the next edge.
  - A stall of exactly TIMEOUT cycles aborts; an ack arriving in stall cycle TIMEOUT-1 or earlier completes normally.
- ERR:
  - s_cyc_o and s_stb_o forced 0.
  - mx_err_o = 1 for the first ERR cycle only. mx_ack_o = 0; s_ack_i is ignored.
  - Remain in ERR until master x drops cyc -> IDLE, last_gnt = x.
- Simultaneous events:
  - Granted master drops cyc in the same cycle s_ack_i rises: the ack is passed through, then IDLE.
  - Timeout and ack in the same cycle: the ack wins and there is no ERR.
- Width rules:
  - Counter width = clog2(TIMEOUT+1); it never wraps.
  - With TIMEOUT=0 the counter and ERR state are unreachable, and no err pulse is ever produced.

Test Plan:
- Reset, then m0 alone writes adr=3'h2, dat=16'hA55A, sel=2'b11. Required: s_* mirrors m0 from cycle 2, gnt_o=01, m0_ack_o follows s_ack_i, and IDLE is entered after cyc drops.
- m0 and m1 raise cyc in the same cycle, three times back-to-back. Required: grant order m0, m1, m0; at least one IDLE cycle between grants; the loser's ack stays 0 throughout.
- m1 holds cyc for 4 consecutive reads (stb pulsed) while m0 requests. Required: m1 keeps the grant for all 4 acks, and m0 is granted only after m1's cyc falls.
- TIMEOUT=8, slave never acks m0. Required: ERR after 8 stalled cycles, m0_err_o high for exactly 1 cycle, s_cyc_o=0; once m0 drops cyc, a pending m1 is granted.
- TIMEOUT=8, ack in stall cycle 7 (the eighth stalled cycle). Required: normal ack with no err. Repeat with TIMEOUT=0 and a 1000-cycle stall: no err.
- Assert rst low mid-transfer in GNT1 with stb high. Required: all outputs go to 0 immediately (asynchronously), gnt_o=00, and after release m0 wins the first contention.
